// File: rtl/throw_ctrl_pkg.sv
// Shared definitions for the bowling throw stage: state encoding, lane geometry
// and small pure helpers used by the controller.
package throw_ctrl_pkg;

  typedef enum logic [1:0] {
    S_AIM   = 2'd0,
    S_POWER = 2'd1,
    S_ROLL  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int LANE_W   = 10;
  localparam int LANE_LEN = 16;
  localparam int PWR_MAX  = 7;

  function automatic logic [3:0] clamp_col(input logic [3:0] col);
    return (col > 4'(LANE_W - 1)) ? 4'(LANE_W - 1) : col;
  endfunction

  // Bit i lit when i <= p, i.e. (1 << (p+1)) - 1.
  function automatic logic [LANE_W-1:0] thermo(input logic [2:0] p);
    logic [LANE_W-1:0] t;
    for (int i = 0; i < LANE_W; i++) t[i] = (i <= int'(p));
    return t;
  endfunction

endpackage

// File: rtl/throw_ctrl_if.sv
// Player/aim side to throw controller bundle. throw is a level; a press is its
// rising edge. done is a one-cycle pulse; final_col is valid from done until the next launch.
interface throw_ctrl_if;
  import throw_ctrl_pkg::*;

  logic [3:0]        aim_pos;
  logic              throw;
  logic [1:0]        state;
  logic [2:0]        power;
  logic [LANE_W-1:0] power_bar;
  logic              ball_valid;
  logic [3:0]        ball_row;
  logic [3:0]        ball_col;
  logic              done;
  logic [3:0]        final_col;

  modport master (
    output aim_pos, throw,
    input  state, power, power_bar, ball_valid, ball_row, ball_col, done, final_col
  );

  modport slave (
    input  aim_pos, throw,
    output state, power, power_bar, ball_valid, ball_row, ball_col, done, final_col
  );

endinterface

// File: rtl/throw_ctrl_tick_gen.sv
// Free-running game-tick divider: one-cycle strobe every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tick = (cnt_q == LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/throw_ctrl.sv
// Throw controller: latches aim, runs a bouncing power meter, rolls the ball
// down the lane at a power-dependent rate and reports the final column.
module throw_ctrl
  import throw_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  throw_ctrl_if.slave  bus
);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick)
  );

  state_e            state_q, state_d;
  logic [2:0]        power_q, power_d;
  logic              dir_up_q, dir_up_d;
  logic [LANE_W-1:0] bar_q, bar_d;
  logic              valid_q, valid_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic              done_q, done_d;
  logic [3:0]        final_q, final_d;
  logic [2:0]        roll_cnt_q, roll_cnt_d;
  logic              throw_q;
  logic              press;

  assign press = bus.throw & ~throw_q;

  always_comb begin
    state_d    = state_q;
    power_d    = power_q;
    dir_up_d   = dir_up_q;
    row_d      = row_q;
    col_d      = col_q;
    done_d     = 1'b0;
    final_d    = final_q;
    roll_cnt_d = roll_cnt_q;

    case (state_q)
      S_AIM: begin
        if (press) begin
          col_d    = clamp_col(bus.aim_pos);
          power_d  = 3'd0;
          dir_up_d = 1'b1;
          state_d  = S_POWER;
        end
      end
      S_POWER: begin
        // A press on a tick edge freezes the current value without stepping.
        if (press) begin
          row_d      = 4'd0;
          roll_cnt_d = 3'd0;
          state_d    = S_ROLL;
        end else if (tick) begin
          if (dir_up_q) begin
            if (power_q == 3'(PWR_MAX)) begin
              power_d  = power_q - 3'd1;
              dir_up_d = 1'b0;
            end else begin
              power_d  = power_q + 3'd1;
            end
          end else begin
            if (power_q == 3'd0) begin
              power_d  = 3'd1;
              dir_up_d = 1'b1;
            end else begin
              power_d  = power_q - 3'd1;
            end
          end
        end
      end
      S_ROLL: begin
        if (tick) begin
          if (roll_cnt_q == 3'(PWR_MAX) - power_q) begin
            roll_cnt_d = 3'd0;
            row_d      = row_q + 4'd1;
            if (row_q + 4'd1 == 4'(LANE_LEN - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              final_d = col_q;
            end
          end else begin
            roll_cnt_d = roll_cnt_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        if (press) begin
          state_d = S_AIM;
          power_d = 3'd0;
          row_d   = 4'd0;
        end
      end
      default: state_d = S_AIM;
    endcase

    valid_d = (state_d == S_ROLL) || (state_d == S_DONE);
    bar_d   = (state_d == S_POWER) ? thermo(power_d) : '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_AIM;
      power_q    <= 3'd0;
      dir_up_q   <= 1'b1;
      bar_q      <= '0;
      valid_q    <= 1'b0;
      row_q      <= 4'd0;
      col_q      <= 4'd0;
      done_q     <= 1'b0;
      final_q    <= 4'd0;
      roll_cnt_q <= 3'd0;
      throw_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      power_q    <= power_d;
      dir_up_q   <= dir_up_d;
      bar_q      <= bar_d;
      valid_q    <= valid_d;
      row_q      <= row_d;
      col_q      <= col_d;
      done_q     <= done_d;
      final_q    <= final_d;
      roll_cnt_q <= roll_cnt_d;
      throw_q    <= bus.throw;
    end
  end

  assign bus.state      = state_q;
  assign bus.power      = power_q;
  assign bus.power_bar  = bar_q;
  assign bus.ball_valid = valid_q;
  assign bus.ball_row   = row_q;
  assign bus.ball_col   = col_q;
  assign bus.done       = done_q;
  assign bus.final_col  = final_q;

endmodule

// File: tb/tb_throw_ctrl.sv
// Bench for throw_ctrl: directed game rounds plus randomized rounds, every
// output compared each cycle against a tick-count based reference model.
module tb_throw_ctrl;
  import throw_ctrl_pkg::*;

  localparam int TDIV = 4;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  throw_ctrl_if bus ();

  throw_ctrl #(.TICK_DIV(TDIV)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: power is a triangle wave of ticks spent in POWER, the
  // row is roll ticks divided by the step period.
  int m_state, m_power, m_col, m_row, m_done, m_final;
  int m_edges, m_prev, m_ptick, m_rticks;
  logic [3:0] exp_q[$];

  function automatic int tri_wave(input int n);
    int r;
    r = n % (2 * PWR_MAX);
    return (r <= PWR_MAX) ? r : (2 * PWR_MAX - r);
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick, press;
    if (reset) begin
      m_state = 0; m_power = 0; m_col = 0; m_row = 0; m_done = 0; m_final = 0;
      m_edges = 0; m_prev = 0; m_ptick = 0; m_rticks = 0;
      exp_q.delete();
      return;
    end
    tick  = (m_edges % TDIV) == (TDIV - 1);
    press = bus.throw && !m_prev;
    m_done = 0;
    case (m_state)
      0: if (press) begin
        m_col = (bus.aim_pos > LANE_W - 1) ? LANE_W - 1 : int'(bus.aim_pos);
        m_ptick = 0; m_power = 0; m_state = 1;
      end
      1: if (press) begin
        m_state = 2; m_rticks = 0; m_row = 0;
        exp_q.push_back(4'(m_col));
      end else if (tick) begin
        m_ptick++;
        m_power = tri_wave(m_ptick);
      end
      2: if (tick) begin
        m_rticks++;
        m_row = m_rticks / (PWR_MAX - m_power + 1);
        if (m_row == LANE_LEN - 1) begin
          m_state = 3; m_done = 1; m_final = m_col;
        end
      end
      default: if (press) begin
        m_state = 0; m_power = 0; m_row = 0;
      end
    endcase
    m_edges++;
    m_prev = bus.throw;
  endtask

  task automatic check_all();
    int bar;
    bar = (m_state == 1) ? ((1 << (m_power + 1)) - 1) : 0;
    chk("state",      10'(bus.state),      10'(m_state));
    chk("power",      10'(bus.power),      10'(m_power));
    chk("power_bar",  bus.power_bar,       10'(bar));
    chk("ball_valid", 10'(bus.ball_valid), 10'(m_state >= 2));
    chk("ball_row",   10'(bus.ball_row),   10'(m_row));
    chk("ball_col",   10'(bus.ball_col),   10'(m_col));
    chk("done",       10'(bus.done),       10'(m_done));
    chk("final_col",  10'(bus.final_col),  10'(m_final));
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) chk("done_unexpected", 10'd1, 10'd0);
      else chk("final_col_sb", 10'(bus.final_col), 10'(exp_q.pop_front()));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(posedge CLOCK_50);
      #1;
      check_all();
    end
  endtask

  task automatic press_hold(input int hold);
    bus.throw = 1'b1;
    step(hold);
    bus.throw = 1'b0;
    step(1);
  endtask

  task automatic wait_state(input string tag, input int s, input int limit);
    int n = 0;
    while (m_state != s && n < limit) begin
      step(1);
      n++;
    end
    chk(tag, 10'(bus.state), 10'(s));
  endtask

  task automatic wait_power(input int p, input int min_ticks, input int limit);
    int n = 0;
    while (!(m_state == 1 && m_power == p && m_ptick >= min_ticks) && n < limit) begin
      step(1);
      n++;
    end
    chk("wait_power", 10'(bus.power), 10'(p));
  endtask

  initial begin
    bus.aim_pos = 4'd0;
    bus.throw   = 1'b0;

    // Reset held three cycles.
    reset = 1'b1;
    step(3);
    chk("reset_state", 10'(bus.state), 10'd0);
    reset = 1'b0;
    step(2);

    // Aim 3, throw held 20 cycles: one entry into POWER, meter runs.
    bus.aim_pos = 4'd3;
    bus.throw   = 1'b1;
    step(20);
    bus.throw   = 1'b0;
    bus.aim_pos = 4'd8;
    chk("ball_col_latched", 10'(bus.ball_col), 10'd3);

    // Launch at power 7: one row per tick, done after 15 ticks.
    wait_power(7, 0, 200);
    press_hold(1);
    wait_state("roll_done_p7", 3, 400);
    chk("row_end_p7", 10'(bus.ball_row), 10'd15);
    step(3);
    press_hold(2);
    chk("back_to_aim", 10'(bus.state), 10'd0);

    // Aim 12 clamps to 9; launch at power 0 after a full bounce.
    bus.aim_pos = 4'd12;
    press_hold(3);
    chk("ball_col_clamp", 10'(bus.ball_col), 10'd9);
    wait_power(0, 2 * PWR_MAX, 400);
    press_hold(1);
    wait_state("roll_done_p0", 3, 1000);
    chk("final_col_p0", 10'(bus.final_col), 10'd9);
    step(2);
    press_hold(1);

    // Randomized rounds, including presses during ROLL that must be ignored.
    for (int r = 0; r < 5; r++) begin
      bus.aim_pos = 4'($urandom_range(0, 15));
      press_hold($urandom_range(1, 6));
      bus.aim_pos = 4'($urandom_range(0, 15));
      step($urandom_range(0, 60));
      press_hold($urandom_range(1, 4));
      step($urandom_range(0, 10));
      press_hold($urandom_range(1, 3));
      wait_state("rand_done", 3, 1000);
      step($urandom_range(1, 5));
      press_hold($urandom_range(1, 3));
    end

    // Reset in the middle of a roll.
    bus.aim_pos = 4'd5;
    press_hold(1);
    step($urandom_range(0, 20));
    press_hold(1);
    begin
      int n = 0;
      while (!(m_state == 2 && m_row == 5) && n < 1000) begin
        step(1);
        n++;
      end
      chk("mid_roll_row", 10'(bus.ball_row), 10'd5);
    end
    reset = 1'b1;
    step(1);
    chk("reset_roll_state", 10'(bus.state), 10'd0);
    chk("reset_roll_valid", 10'(bus.ball_valid), 10'd0);
    reset = 1'b0;

    // Full round to DONE, then press back to AIM keeps final_col.
    bus.aim_pos = 4'd6;
    press_hold(1);
    step($urandom_range(0, 30));
    press_hold(1);
    wait_state("last_done", 3, 1000);
    press_hold(1);
    chk("final_kept", 10'(bus.final_col), 10'd6);
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
